shift_add_multiplier: RTL and testbench

Multi-cycle unsigned multiply-accumulate unit computing `multiplicand_in * multiplier_in + addend_in`, one partial product per clock. It is the inverse datapath of the non-restoring divider: feeding it a quotient, divisor and remainder rebuilds the dividend. It uses the same `start`/`done` handshake as the divider, so the π-calculation datapath can chain divide and reconstruct/check steps through one controller.

---
 rtl/arith_pkg.sv | 13 +
 rtl/shift_add_multiplier.sv | 96 +++++++++
 tb/tb_shift_add_multiplier.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared sequencing types and defaults for the multi-cycle arithmetic units
// (divider, shift-add multiplier and their controller).
package arith_pkg;

    localparam int ARITH_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } seq_state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned multiply-accumulate: product_out = A*B + C, one partial
// product per clock, using the same start/busy/done handshake as the divider.
module shift_add_multiplier
    import arith_pkg::*;
#(
    parameter int P_WIDTH = ARITH_DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [P_WIDTH-1:0]     multiplicand_in,
    input  logic [P_WIDTH-1:0]     multiplier_in,
    input  logic [P_WIDTH-1:0]     addend_in,
    output logic [2*P_WIDTH-1:0]   product_out,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = $clog2(P_WIDTH) + 1;
    localparam int ACC_W = 2 * P_WIDTH;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(P_WIDTH - 1);

    seq_state_t        state_q;
    logic [ACC_W-1:0]  mcand_q;
    logic [P_WIDTH-1:0] mplr_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ACC_W-1:0]  product_q;
    logic              busy_q;
    logic              done_q;

    // The multiplicand register is pre-shifted one place per iteration, so it
    // always equals A << cnt_q without needing a barrel shifter.
    always_comb begin
        acc_d = acc_q;
        if (mplr_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q <= {{P_WIDTH{1'b0}}, multiplicand_in};
                        mplr_q  <= multiplier_in;
                        acc_q   <= {{P_WIDTH{1'b0}}, addend_in};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= mplr_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        product_q <= acc_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign product_out = product_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at P_WIDTH=32.
module tb_shift_add_multiplier;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand_in;
    logic [W-1:0]   multiplier_in;
    logic [W-1:0]   addend_in;
    logic [2*W-1:0] product_out;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.P_WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
        .addend_in       (addend_in),
        .product_out     (product_out),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents operands with start high for exactly one accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        multiplicand_in = a;
        multiplier_in   = b;
        addend_in       = c;
        start           = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles from the last edge seen until done is observed high; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        logic [63:0] exp;
        int qv[6];
        int dv[6];
        qv = '{0, 1, 51, 128, 200, 255};
        dv = '{1, 2, 3, 127, 128, 255};

        rst = 1'b1;
        start = 1'b0;
        multiplicand_in = '0;
        multiplier_in = '0;
        addend_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_product", product_out, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);

        // Basic 7*6+5
        launch(32'd7, 32'd6, 32'd5);
        check("basic_busy_after_accept", {63'd0, busy}, 64'd1);
        wait_done(lat);
        check("basic_latency", 64'(lat), 64'd32);
        check("basic_product", product_out, 64'd47);
        @(posedge clk);
        #1;
        check("basic_done_low", {63'd0, done}, 64'd0);
        check("basic_busy_low", {63'd0, busy}, 64'd0);
        check("basic_product_held", product_out, 64'd47);

        // Divider round-trip: q*d + r with r = d-1 and r = 0
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                for (int t = 0; t < 2; t++) begin
                    int r;
                    r = (t == 0) ? dv[j] - 1 : 0;
                    exp = 64'(qv[i] * dv[j] + r);
                    launch(W'(qv[i]), W'(dv[j]), W'(r));
                    wait_done(lat);
                    check($sformatf("roundtrip_q%0d_d%0d_r%0d", qv[i], dv[j], r), product_out, exp);
                    @(posedge clk);
                    #1;
                end
            end
        end

        // Extreme operands
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        check("max_latency", 64'(lat), 64'd32);
        check("max_product", product_out, 64'hFFFF_FFFF_0000_0000);
        @(posedge clk);
        #1;
        launch(32'd0, 32'hFFFF_FFFF, 32'd0);
        wait_done(lat);
        check("zero_a_latency", 64'(lat), 64'd32);
        check("zero_a_product", product_out, 64'd0);
        @(posedge clk);
        #1;

        // start re-pulsed mid-job is ignored
        launch(32'd100, 32'd200, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        multiplicand_in = 32'd1;
        multiplier_in = 32'd1;
        addend_in = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        check("ignore_start_latency", 64'(lat), 64'd22);
        check("ignore_start_product", product_out, 64'd20003);
        wait_done(lat);
        check("ignore_start_no_second_job", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        check("ignore_start_idle", {63'd0, busy}, 64'd0);

        // start held high: done every P_WIDTH+2 cycles
        multiplicand_in = 32'd5;
        multiplier_in = 32'd5;
        addend_in = 32'd0;
        start = 1'b1;
        wait_done(lat);
        check("held_first_latency", 64'(lat), 64'd33);
        wait_done(lat);
        check("held_period_1", 64'(lat), 64'd34);
        check("held_product", product_out, 64'd25);
        wait_done(lat);
        check("held_period_2", 64'(lat), 64'd34);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("held_release_idle", {63'd0, busy}, 64'd0);

        // Reset mid-operation
        launch(32'd3, 32'd4, 32'd0);
        repeat (14) @(posedge clk);
        #2;
        check("midrst_busy_before", {63'd0, busy}, 64'd1);
        check("midrst_product_before", product_out, 64'd25);
        rst = 1'b1;
        #1;
        check("midrst_product", product_out, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_done(lat);
        check("midrst_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        check("midrst_product_after", product_out, 64'd0);
        launch(32'd2, 32'd9, 32'd1);
        wait_done(lat);
        check("post_rst_latency", 64'(lat), 64'd32);
        check("post_rst_product", product_out, 64'd19);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
